tour_cmd: RTL and testbench

Command scheduler between the UART command path and `cmd_proc`. It owns `cmd_proc`'s command input:
- **Idle:** it forwards remote UART commands to `cmd_proc` unchanged.
- **Tour:** after `start_tour`, it replays the 24-move solution stored by `TourLogic`. Each knight move is split into a vertical leg and a horizontal leg, and each leg is handed to `cmd_proc` with a ready/clear/response handshake.

It sits in `KnightsTour` between `UART_wrapper`, `TourLogic` and `cmd_proc`.

---
 rtl/tour_pkg.sv | 23 ++
 rtl/kt_move_decode.sv | 41 ++++
 rtl/tour_cmd.sv | 111 +++++++++++
 tb/tb_tour_cmd.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// rtl/tour_pkg.sv - shared constants and state type for the tour command scheduler
package tour_pkg;

   localparam logic [3:0] OP_MOVE    = 4'b0010;
   localparam logic [3:0] OP_MOVE_FF = 4'b0011;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_POS = 8'h5A;

   typedef enum logic [2:0] {
      S_IDLE,
      S_VERT,
      S_WAIT_V,
      S_HORZ,
      S_WAIT_H
   } tour_state_t;

endpackage

// File: rtl/kt_move_decode.sv
// rtl/kt_move_decode.sv - one-hot knight move to vertical and horizontal leg commands
module kt_move_decode (
   input  logic [7:0]  move,
   output logic [15:0] vert_cmd,
   output logic [15:0] horz_cmd
);
   import tour_pkg::*;

   logic [7:0] v_hdg;
   logic [7:0] h_hdg;
   logic [3:0] v_sq;
   logic [3:0] h_sq;

   // Lowest set bit wins; an empty move becomes two zero-length north legs.
   always_comb begin
      v_hdg = HDG_N;
      h_hdg = HDG_N;
      v_sq  = 4'd0;
      h_sq  = 4'd0;
      casez (move)
         8'b???????1: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
         8'b??????10: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
         8'b?????100: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
         8'b????1000: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
         8'b???10000: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
         8'b??100000: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
         8'b?1000000: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
         8'b10000000: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
         default: begin
            v_hdg = HDG_N;
            h_hdg = HDG_N;
            v_sq  = 4'd0;
            h_sq  = 4'd0;
         end
      endcase
   end

   assign vert_cmd = {OP_MOVE, v_hdg, v_sq};
   assign horz_cmd = {OP_MOVE_FF, h_hdg, h_sq};

endmodule

// File: rtl/tour_cmd.sv
// rtl/tour_cmd.sv - forwards UART commands when idle, replays the stored knight's tour otherwise
module tour_cmd #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);
   import tour_pkg::*;

   localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

   tour_state_t state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic [15:0] vert_cmd, horz_cmd;
   logic        last_move;

   kt_move_decode u_decode (
      .move     (move),
      .vert_cmd (vert_cmd),
      .horz_cmd (horz_cmd)
   );

   assign last_move = (mv_indx_q == LAST_IDX);
   assign mv_indx   = mv_indx_q;

   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      case (state_q)
         S_IDLE: begin
            if (start_tour) begin
               state_d   = S_VERT;
               mv_indx_d = 5'd0;
            end
         end
         S_VERT:   if (clr_cmd_rdy) state_d = S_WAIT_V;
         S_WAIT_V: if (send_resp)   state_d = S_HORZ;
         S_HORZ:   if (clr_cmd_rdy) state_d = S_WAIT_H;
         S_WAIT_H: begin
            if (send_resp) begin
               if (last_move) begin
                  state_d   = S_IDLE;
                  mv_indx_d = 5'd0;
               end else begin
                  state_d   = S_VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
               end
            end
         end
         default: begin
            state_d   = S_IDLE;
            mv_indx_d = 5'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   // UART handshake is only wired through while idle, so a command arriving mid-tour stays pending.
   always_comb begin
      cmd              = cmd_UART;
      cmd_rdy          = 1'b0;
      clr_cmd_rdy_UART = 1'b0;
      resp             = RESP_POS;
      case (state_q)
         S_IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_ACK;
         end
         S_VERT: begin
            cmd     = vert_cmd;
            cmd_rdy = 1'b1;
         end
         S_WAIT_V: cmd = vert_cmd;
         S_HORZ: begin
            cmd     = horz_cmd;
            cmd_rdy = 1'b1;
         end
         S_WAIT_H: begin
            cmd  = horz_cmd;
            resp = last_move ? RESP_ACK : RESP_POS;
         end
         default: begin
            cmd     = cmd_UART;
            cmd_rdy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tour_cmd.sv
// tb/tb_tour_cmd.sv - randomized self-checking bench for tour_cmd against a leg-counting model
module tb_tour_cmd;

   localparam int NUM_LEGS = 48;
   localparam int DXS[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
   localparam int DYS[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   logic [7:0]  tour_moves [32];
   logic [15:0] lit_legs [6];

   int n_checks = 0;
   int n_pass   = 0;

   // model: tour active flag, count of legs handed out, and whether the current leg was accepted
   bit m_active;
   int m_leg;
   bit m_wait;

   tour_cmd #(.NUM_MOVES(24)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_UART         (cmd_UART),
      .cmd_rdy_UART     (cmd_rdy_UART),
      .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
      .start_tour       (start_tour),
      .move             (move),
      .mv_indx          (mv_indx),
      .cmd              (cmd),
      .cmd_rdy          (cmd_rdy),
      .clr_cmd_rdy      (clr_cmd_rdy),
      .send_resp        (send_resp),
      .resp             (resp)
   );

   always #5 clk = ~clk;

   assign move = tour_moves[mv_indx];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] leg_cmd(input logic [7:0] mv, input bit horiz);
      int dx = 0;
      int dy = 0;
      int d;
      logic [7:0] hd;
      logic [3:0] op;
      for (int i = 7; i >= 0; i--) begin
         if (mv[i]) begin
            dx = DXS[i];
            dy = DYS[i];
         end
      end
      if (!horiz) begin
         d  = dy;
         op = 4'h2;
         hd = (dy < 0) ? 8'h7F : 8'h00;
      end else begin
         d  = dx;
         op = 4'h3;
         hd = (dx > 0) ? 8'hBF : ((dx < 0) ? 8'h3F : 8'h00);
      end
      if (d < 0) d = -d;
      return {op, hd, 4'(d)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_leg    <= 0;
         m_wait   <= 1'b0;
      end else if (!m_active) begin
         if (start_tour) begin
            m_active <= 1'b1;
            m_leg    <= 0;
            m_wait   <= 1'b0;
         end
      end else if (!m_wait) begin
         if (clr_cmd_rdy) m_wait <= 1'b1;
      end else if (send_resp) begin
         m_wait <= 1'b0;
         if (m_leg == NUM_LEGS - 1) begin
            m_active <= 1'b0;
            m_leg    <= 0;
         end else begin
            m_leg <= m_leg + 1;
         end
      end
   end

   always @(negedge clk) begin
      check("mv_indx", {11'd0, mv_indx}, 16'(m_leg / 2));
      if (!m_active) begin
         check("idle_cmd", cmd, cmd_UART);
         check("idle_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, cmd_rdy_UART});
         check("idle_clr_uart", {15'd0, clr_cmd_rdy_UART}, {15'd0, clr_cmd_rdy});
         check("idle_resp", {8'd0, resp}, 16'h00A5);
      end else begin
         check("tour_cmd_rdy", {15'd0, cmd_rdy}, {15'd0, !m_wait});
         check("tour_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd0);
         if (!m_wait)
            check("tour_leg", cmd, leg_cmd(tour_moves[m_leg / 2], m_leg[0]));
         check("tour_resp", {8'd0, resp},
               (m_wait && m_leg == NUM_LEGS - 1) ? 16'h00A5 : 16'h005A);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_tour(input int tid, input int uart_leg, input int abort_leg);
      int waitc;
      start_tour = 1'b1;
      tick();
      start_tour = 1'b0;
      for (int leg = 0; leg < NUM_LEGS; leg++) begin
         waitc = 0;
         while (!cmd_rdy && waitc < 20) begin
            tick();
            waitc++;
         end
         if (!cmd_rdy) begin
            check("leg_timeout", {15'd0, cmd_rdy}, 16'd1);
            return;
         end
         if (tid == 0 && leg < 6) check("literal_leg", cmd, lit_legs[leg]);
         if (leg == uart_leg) begin
            cmd_UART     = 16'h2ABC;
            cmd_rdy_UART = 1'b1;
         end
         if (leg == abort_leg) begin
            rst_n = 1'b0;
            #1;
            check("abort_mv_indx", {11'd0, mv_indx}, 16'd0);
            check("abort_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
            check("abort_resp", {8'd0, resp}, 16'h00A5);
            tick();
            rst_n = 1'b1;
            tick();
            return;
         end
         repeat ($urandom_range(0, 2)) begin
            send_resp = 1'($urandom_range(0, 1));
            tick();
            send_resp = 1'b0;
         end
         clr_cmd_rdy = 1'b1;
         tick();
         clr_cmd_rdy = 1'b0;
         check("cmd_rdy_drop", {15'd0, cmd_rdy}, 16'd0);
         repeat ($urandom_range(0, 2)) begin
            clr_cmd_rdy = 1'($urandom_range(0, 1));
            start_tour  = 1'($urandom_range(0, 1));
            tick();
            clr_cmd_rdy = 1'b0;
            start_tour  = 1'b0;
         end
         check("wait_resp", {8'd0, resp}, (leg == NUM_LEGS - 1) ? 16'h00A5 : 16'h005A);
         send_resp = 1'b1;
         tick();
         send_resp = 1'b0;
      end
      check("end_mv_indx", {11'd0, mv_indx}, 16'd0);
   endtask

   initial begin
      lit_legs = '{16'h2002, 16'h3BF1, 16'h2000, 16'h3000, 16'h27F2, 16'h33F1};
      for (int i = 0; i < 32; i++) tour_moves[i] = 8'(1 << (i % 8));
      rst_n        = 1'b0;
      cmd_UART     = 16'h1234;
      cmd_rdy_UART = 1'b0;
      start_tour   = 1'b0;
      clr_cmd_rdy  = 1'b0;
      send_resp    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mv_indx", {11'd0, mv_indx}, 16'd0);
      check("rst_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      check("rst_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd0);
      check("rst_resp", {8'd0, resp}, 16'h00A5);
      check("rst_cmd", cmd, 16'h1234);
      rst_n = 1'b1;
      tick();

      cmd_UART     = 16'h2004;
      cmd_rdy_UART = 1'b1;
      #1;
      check("pass_cmd", cmd, 16'h2004);
      check("pass_cmd_rdy", {15'd0, cmd_rdy}, 16'd1);
      check("pass_resp", {8'd0, resp}, 16'h00A5);
      clr_cmd_rdy = 1'b1;
      #1;
      check("pass_clr_uart", {15'd0, clr_cmd_rdy_UART}, 16'd1);
      tick();
      clr_cmd_rdy  = 1'b0;
      cmd_rdy_UART = 1'b0;
      tick();

      tour_moves[0] = 8'h01;
      tour_moves[1] = 8'h00;
      tour_moves[2] = 8'h30;
      run_tour(0, -1, -1);
      tick();

      for (int i = 0; i < 24; i++) tour_moves[i] = 8'($urandom_range(0, 255));
      run_tour(1, 10, -1);
      check("uart_after_cmd", cmd, 16'h2ABC);
      check("uart_after_rdy", {15'd0, cmd_rdy}, 16'd1);
      clr_cmd_rdy = 1'b1;
      #1;
      check("uart_after_clr", {15'd0, clr_cmd_rdy_UART}, 16'd1);
      tick();
      clr_cmd_rdy  = 1'b0;
      cmd_rdy_UART = 1'b0;
      tick();

      for (int i = 0; i < 32; i++) tour_moves[i] = 8'(1 << (i % 8));
      run_tour(2, -1, 21);
      check("post_abort_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      check("post_abort_mv_indx", {11'd0, mv_indx}, 16'd0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
